// File: rtl/instr_pkg.sv
// Shared opcode map, request field positions, format helper and loader state enumeration.
// The CHK state exists only when INSTR_LOADER_READBACK_EN is defined.
package instr_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_ADDIU = 6'd2;
    localparam logic [5:0] OP_ANDI  = 6'd3;
    localparam logic [5:0] OP_ORI   = 6'd4;
    localparam logic [5:0] OP_XORI  = 6'd5;
    localparam logic [5:0] OP_SLTI  = 6'd6;
    localparam logic [5:0] OP_SLTIU = 6'd7;
    localparam logic [5:0] OP_LUI   = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd9;
    localparam logic [5:0] OP_LB    = 6'd10;
    localparam logic [5:0] OP_SW    = 6'd11;
    localparam logic [5:0] OP_J     = 6'd12;
    localparam logic [5:0] OP_JAL   = 6'd13;
    localparam logic [5:0] OP_JAL2  = 6'd14;

    // Positions inside the packed in_regs request field
    localparam int REG_W     = 5;
    localparam int RS_LSB    = 15;
    localparam int RT_LSB    = 10;
    localparam int RD_LSB    = 5;
    localparam int SHAMT_LSB = 0;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_BAD
    } fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENC,
        ST_WR,
        ST_FIN
`ifdef INSTR_LOADER_READBACK_EN
        , ST_CHK
`endif
    } state_t;

    function automatic fmt_t op_format(input logic [5:0] op);
        case (op)
            OP_RTYPE: return FMT_R;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
            OP_SLTIU, OP_LUI, OP_LW, OP_LB, OP_SW: return FMT_I;
            OP_J, OP_JAL, OP_JAL2: return FMT_J;
            default: return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Request handshake plus instruction-memory write/read port of the instruction loader.
// master = request source / memory side, slave = loader side.
interface instr_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [19:0]       in_regs;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       imem_rdata;

    modport master (
        output in_valid, in_opcode, in_regs, in_funct, in_imm, in_target, in_last,
        input  in_ready,
        input  imem_we, imem_addr, imem_wdata,
        output imem_rdata
    );

    modport slave (
        input  in_valid, in_opcode, in_regs, in_funct, in_imm, in_target, in_last,
        output in_ready,
        output imem_we, imem_addr, imem_wdata,
        input  imem_rdata
    );
endinterface

// File: rtl/instr_word_enc.sv
// Pure combinational instruction encoder: opcode always lands in bits [31:26];
// opcodes outside the R/I/J map raise illegal and produce a zero word.
module instr_word_enc
    import instr_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [19:0] regs,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);
    logic [4:0] rs, rt, rd, shamt;

    assign rs    = regs[RS_LSB    +: REG_W];
    assign rt    = regs[RT_LSB    +: REG_W];
    assign rd    = regs[RD_LSB    +: REG_W];
    assign shamt = regs[SHAMT_LSB +: REG_W];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        word    = '0;
        illegal = 1'b0;
        case (op_format(opcode))
            FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, target};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_loader.sv
// Instruction loader FSM: capture request, encode, write one IMEM word per request.
// Define INSTR_LOADER_READBACK_EN to add a CHK state that verifies each write through imem_rdata.
module instr_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_loader_if.slave   bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            full,
    output logic [ADDR_W:0] word_count
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t          state, state_nxt;
    logic [5:0]      op_q;
    logic [19:0]     regs_q;
    logic [5:0]      funct_q;
    logic [15:0]     imm_q;
    logic [25:0]     target_q;
    logic            last_q;
    logic [31:0]     word_q;
    logic [ADDR_W:0] cnt_q;
    logic [31:0]     enc_word;
    logic            enc_illegal;
    logic            accept;
    logic            advance;
    logic            fin_cond;

    instr_word_enc u_enc (
        .opcode  (op_q),
        .regs    (regs_q),
        .funct   (funct_q),
        .imm     (imm_q),
        .target  (target_q),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign full         = (cnt_q == DEPTH_C);
    assign done         = (state == ST_FIN);
    assign word_count   = cnt_q;
    assign bus.in_ready = (state == ST_IDLE) && !full && !done;
    assign accept       = bus.in_valid && bus.in_ready && !start;
    assign fin_cond     = last_q || ((cnt_q + CNT_ONE) == DEPTH_C);

    // start gates the strobe so an abort during WR never commits a word
    assign bus.imem_we    = (state == ST_WR) && !full && !start;
    assign bus.imem_addr  = cnt_q[ADDR_W] ? '1 : cnt_q[ADDR_W-1:0];
    assign bus.imem_wdata = word_q;

`ifdef INSTR_LOADER_READBACK_EN
    assign busy    = (state == ST_ENC) || (state == ST_WR) || (state == ST_CHK);
    assign advance = (state == ST_CHK) && !start;
`else
    assign busy    = (state == ST_ENC) || (state == ST_WR);
    assign advance = (state == ST_WR) && !full && !start;
`endif

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        if (start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nxt = ST_ENC;
                ST_ENC: begin
                    if (enc_illegal) begin
                        err       = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
`ifdef INSTR_LOADER_READBACK_EN
                ST_WR:  state_nxt = ST_CHK;
                ST_CHK: begin
                    if (bus.imem_rdata != word_q) begin
                        err       = 1'b1;
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = fin_cond ? ST_FIN : ST_IDLE;
                    end
                end
`else
                ST_WR:  state_nxt = fin_cond ? ST_FIN : ST_IDLE;
`endif
                ST_FIN:  state_nxt = ST_FIN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            op_q     <= '0;
            regs_q   <= '0;
            funct_q  <= '0;
            imm_q    <= '0;
            target_q <= '0;
            last_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values, independent of order.
            state <= state_nxt;
            if (start) begin
                cnt_q <= '0;
            end else if (advance) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (accept) begin
                op_q     <= bus.in_opcode;
                regs_q   <= bus.in_regs;
                funct_q  <= bus.in_funct;
                imm_q    <= bus.in_imm;
                target_q <= bus.in_target;
                last_q   <= bus.in_last;
            end
            if ((state == ST_ENC) && !enc_illegal && !start) begin
                word_q <= enc_word;
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (DEPTH = 2**ADDR_W = 4): vector table, corner sequences,
// and randomized requests against a field-arithmetic reference model.
module tb_instr_loader;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [5:0]  op;
        logic [19:0] regs;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        illegal;
        logic [31:0] word;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, err, full;
    logic [ADDR_W:0] word_count;
    logic            corrupt = 1'b0;
    logic [31:0]     mem [DEPTH];
    int              checks = 0;
    int              errors = 0;
    int              we_pulses = 0;
    vec_t            vecs [10];

    instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .full       (full),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) begin
            mem[bus.imem_addr] <= bus.imem_wdata;
            we_pulses          <= we_pulses + 1;
        end
    end
    assign bus.imem_rdata = mem[bus.imem_addr] ^ {31'd0, corrupt};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input vec_t v);
        int unsigned op, rs, rt, rd, sh;
        op = v.op;
        rs = (v.regs >> 15) & 31;
        rt = (v.regs >> 10) & 31;
        rd = (v.regs >> 5) & 31;
        sh = v.regs & 31;
        if (op == 0) return op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + v.funct;
        if (op <= 11) return op * 67108864 + rs * 2097152 + rt * 65536 + v.imm;
        return op * 67108864 + v.target;
    endfunction

    // All tasks start and end just after a falling edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic last, output logic ok,
                        output logic err_enc, output logic we_enc, output logic err_wr,
                        output logic we_wr, output logic [ADDR_W-1:0] addr, output logic [31:0] data);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.in_ready === 1'b1);
        err_enc = 1'b0; we_enc = 1'b0; err_wr = 1'b0; we_wr = 1'b0; addr = '0; data = '0;
        if (!ok) return;
        bus.in_valid  = 1'b1;
        bus.in_opcode = v.op;
        bus.in_regs   = v.regs;
        bus.in_funct  = v.funct;
        bus.in_imm    = v.imm;
        bus.in_target = v.target;
        bus.in_last   = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        err_enc = err;
        we_enc  = bus.imem_we;
        @(negedge clk);
        err_wr = err;
        we_wr  = bus.imem_we;
        addr   = bus.imem_addr;
        data   = bus.imem_wdata;
    endtask

    task automatic wait_idle(output logic ok);
        int n = 0;
        while (busy !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    initial begin
        logic ok, e_enc, w_enc, e_wr, w_wr;
        logic [ADDR_W-1:0] a;
        logic [31:0] d;
        int exp_cnt, pulses0;
        bit exp_done;
        vec_t v;

        vecs[0] = '{6'd1,  {5'd2, 5'd3, 5'd0, 5'd0},   6'h00, 16'h0010, 26'd0,        1'b0, 32'h04430010};
        vecs[1] = '{6'd0,  {5'd1, 5'd2, 5'd3, 5'd0},   6'h20, 16'hBEEF, 26'h155,      1'b0, 32'h00221820};
        vecs[2] = '{6'd12, 20'hFFFFF,                  6'h3F, 16'hFFFF, 26'h0000040,  1'b0, 32'h30000040};
        vecs[3] = '{6'd13, 20'd0,                      6'h00, 16'h0000, 26'h3FFFFFF,  1'b0, 32'h37FFFFFF};
        vecs[4] = '{6'd11, {5'd31, 5'd0, 5'd7, 5'd7},  6'h15, 16'hFFFF, 26'h1,        1'b0, 32'h2FE0FFFF};
        vecs[5] = '{6'd0,  {5'd0, 5'd5, 5'd7, 5'd31},  6'h3F, 16'h0000, 26'd0,        1'b0, 32'h00053FFF};
        vecs[6] = '{6'd15, 20'h12345,                  6'h01, 16'h1234, 26'h1234,     1'b1, 32'h0};
        vecs[7] = '{6'h3F, 20'hFFFFF,                  6'h3F, 16'hFFFF, 26'h3FFFFFF,  1'b1, 32'h0};
        vecs[8] = '{6'd14, 20'hABCDE,                  6'h2A, 16'h5555, 26'h0,        1'b0, 32'h38000000};
        vecs[9] = '{6'd8,  {5'd0, 5'd9, 5'd1, 5'd1},   6'h3F, 16'h1234, 26'h2AAAAAA,  1'b0, 32'h20091234};

        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_regs = '0; bus.in_funct = '0;
        bus.in_imm = '0; bus.in_target = '0; bus.in_last = 1'b0;

        // Reset values and ready straight after release
        #3;
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        check("rst_count", word_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_reset", bus.in_ready, 1);
        @(negedge clk);

        // Vector table: one request per fresh program
        foreach (vecs[i]) begin
            pulse_start();
            send(vecs[i], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
            check("vec_handshake", ok, 1);
            check("vec_we_in_enc", w_enc, 0);
            if (vecs[i].illegal) begin
                check("vec_err_pulse", e_enc, 1);
                check("vec_err_one_cycle", e_wr, 0);
                check("vec_no_write", w_wr, 0);
                check("vec_ready_back", bus.in_ready, 1);
                check("vec_count_same", word_count, 0);
            end else begin
                check("vec_no_err", e_enc, 0);
                check("vec_we_latency", w_wr, 1);
                check("vec_addr", a, 0);
                check("vec_word", d, vecs[i].word);
                wait_idle(ok);
                check("vec_idle", ok, 1);
                check("vec_count", word_count, 1);
            end
        end

        // Two-word program: second word lands at address 1
        pulse_start();
        send(vecs[1], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
        wait_idle(ok);
        send(vecs[2], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
        check("seq_j_addr", a, 1);
        check("seq_j_word", d, 32'h30000040);
        wait_idle(ok);
        check("seq_count2", word_count, 2);

        // Fill to DEPTH without in_last
        pulse_start();
        for (int k = 0; k < DEPTH; k++) begin
            send(vecs[0], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
            check("fill_addr", a, k);
            wait_idle(ok);
        end
        check("fill_full", full, 1);
        check("fill_done", done, 1);
        check("fill_ready", bus.in_ready, 0);
        pulses0 = we_pulses;
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        check("fill_no_extra_write", we_pulses - pulses0, 0);
        check("fill_done_held", done, 1);
        pulse_start();
        check("restart_count", word_count, 0);
        check("restart_ready", bus.in_ready, 1);
        check("restart_full", full, 0);
        check("restart_done", done, 0);

        // in_last finishes the program
        send(vecs[3], 1'b1, ok, e_enc, w_enc, e_wr, w_wr, a, d);
        wait_idle(ok);
        check("last_done", done, 1);
        check("last_count", word_count, 1);
        check("last_ready", bus.in_ready, 0);

        // start during ENC aborts without a write
        pulse_start();
        pulses0 = we_pulses;
        bus.in_valid = 1'b1; bus.in_opcode = 6'd1; bus.in_last = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort_enc_busy", busy, 1);
        pulse_start();
        repeat (2) @(negedge clk);
        check("abort_enc_no_write", we_pulses - pulses0, 0);
        check("abort_enc_count", word_count, 0);
        check("abort_enc_idle", busy, 0);

        // start during WR suppresses the strobe immediately
        send(vecs[0], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
        check("abort_wr_we_before", w_wr, 1);
        pulses0 = we_pulses;
        start = 1'b1;
        #1 check("abort_wr_we_gated", bus.imem_we, 0);
        @(negedge clk);
        start = 1'b0;
        check("abort_wr_no_write", we_pulses - pulses0, 0);
        check("abort_wr_count", word_count, 0);

        // handshake coinciding with start is ignored
        start = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.in_valid = 1'b0;
        check("start_hs_ignored", busy, 0);
        @(negedge clk);
        check("start_hs_no_write", bus.imem_we, 0);

        // Asynchronous reset during WR
        send(vecs[4], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
        check("rstwr_we_before", w_wr, 1);
        rst_n = 1'b0;
        #1;
        check("rstwr_we", bus.imem_we, 0);
        check("rstwr_wdata", bus.imem_wdata, 0);
        check("rstwr_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwr_count", word_count, 0);
        check("rstwr_addr", bus.imem_addr, 0);
        check("rstwr_done", done, 0);
        check("rstwr_err", err, 0);
        check("rstwr_ready", bus.in_ready, 1);

`ifdef INSTR_LOADER_READBACK_EN
        // Corrupted read-back: err in CHK, then FIN with the pointer advanced
        pulse_start();
        corrupt = 1'b1;
        send(vecs[0], 1'b0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
        check("rb_we", w_wr, 1);
        @(negedge clk);
        check("rb_err_chk", err, 1);
        check("rb_busy_chk", busy, 1);
        @(negedge clk);
        check("rb_done", done, 1);
        check("rb_err_gone", err, 0);
        check("rb_count", word_count, 1);
        corrupt = 1'b0;
`endif

        // Randomized requests against the reference model
        pulse_start();
        exp_cnt = 0;
        exp_done = 0;
        for (int t = 0; t < 120; t++) begin
            if (exp_done || $urandom_range(0, 15) == 0) begin
                if (exp_done) check("rnd_ready_low", bus.in_ready, 0);
                pulse_start();
                exp_cnt = 0;
                exp_done = 0;
                check("rnd_restart_count", word_count, 0);
            end
            v.op     = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(15, 63)) : 6'($urandom_range(0, 14));
            v.regs   = 20'($urandom);
            v.funct  = 6'($urandom);
            v.imm    = 16'($urandom);
            v.target = 26'($urandom);
            send(v, $urandom_range(0, 5) == 0, ok, e_enc, w_enc, e_wr, w_wr, a, d);
            check("rnd_handshake", ok, 1);
            if (v.op > 14) begin
                check("rnd_err", e_enc, 1);
                check("rnd_no_write", w_wr, 0);
            end else begin
                check("rnd_no_err", e_enc, 0);
                check("rnd_we", w_wr, 1);
                check("rnd_addr", a, exp_cnt);
                check("rnd_word", d, model_word(v));
                exp_cnt++;
                if (bus.in_last || exp_cnt == DEPTH) exp_done = 1;
            end
            wait_idle(ok);
            check("rnd_idle", ok, 1);
            check("rnd_count", word_count, exp_cnt);
            check("rnd_done", done, exp_done);
            check("rnd_full", full, exp_cnt == DEPTH);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
